atm_session_ctrl: RTL and testbench

//  Multi-account ATM session controller: card -> language -> PIN -> service -> another-service loop.

---
 rtl/atm_pkg.sv | 44 ++++
 rtl/atm_timeout_timer.sv | 37 +++
 rtl/atm_session_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared encodings for the ATM session controller: FSM state codes, front-panel
// input codes and the status event codes shown on the display.
package atm_pkg;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LANG     = 4'd1;
    localparam logic [3:0] S_PIN      = 4'd2;
    localparam logic [3:0] S_SERVICE  = 4'd3;
    localparam logic [3:0] S_DEPOSIT  = 4'd4;
    localparam logic [3:0] S_WITHDRAW = 4'd5;
    localparam logic [3:0] S_BALANCE  = 4'd6;
    localparam logic [3:0] S_ANOTHER  = 4'd7;

    typedef enum logic [2:0] {
        ST_NONE     = 3'd0,
        ST_OK       = 3'd1,
        ST_BADPIN   = 3'd2,
        ST_LOCKED   = 3'd3,
        ST_NOFUNDS  = 3'd4,
        ST_OVERFLOW = 3'd5,
        ST_TIMEOUT  = 3'd6,
        ST_BYE      = 3'd7
    } status_e;

    typedef enum logic [2:0] {
        SVC_NONE     = 3'b000,
        SVC_DEPOSIT  = 3'b001,
        SVC_WITHDRAW = 3'b010,
        SVC_BALANCE  = 3'b011
    } service_e;

    typedef enum logic [1:0] {
        LANG_NONE = 2'b00,
        LANG_EN   = 2'b01,
        LANG_DE   = 2'b10
    } lang_e;

    // States in which the customer is expected to act and may therefore time out.
    function automatic logic is_timed_state(input logic [3:0] s);
        return (s == S_LANG) || (s == S_PIN) || (s == S_SERVICE) ||
               (s == S_DEPOSIT) || (s == S_WITHDRAW) || (s == S_ANOTHER);
    endfunction

endpackage

// File: rtl/atm_timeout_timer.sv
// Idle-cycle down-counter: reloads on clear, counts down while ticking, and
// flags expired on the last tolerated cycle of a waiting state.
module atm_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = LOAD;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/atm_session_ctrl.sv
// Multi-account ATM session controller with on-chip balances, PIN lockout and
// per-state timeout.
//   state    | meaning
//   IDLE     | no card, waiting for cardno != 0
//   LANG     | card accepted, waiting for language choice
//   PIN      | waiting for a PIN attempt
//   SERVICE  | waiting for deposit / withdraw / balance choice
//   DEPOSIT  | waiting for a non-zero amount to add
//   WITHDRAW | waiting for a non-zero amount to remove
//   BALANCE  | one-cycle balance report
//   ANOTHER  | waiting for another-service answer
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int CARD_W         = 8,
    parameter int PIN_W          = 4,
    parameter int AMOUNT_W       = 5,
    parameter int BALANCE_W      = 8,
    parameter int NUM_ACCOUNTS   = 4,
    parameter int INIT_BALANCE   = 0,
    parameter int TIMEOUT_CYCLES = 5,
    parameter int MAX_PIN_TRIES  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CARD_W-1:0]    cardno,
    input  logic [1:0]           language,
    input  logic [PIN_W-1:0]     pin,
    input  logic                 pin_valid,
    input  logic [PIN_W-1:0]     correct_pin,
    input  logic [2:0]           service,
    input  logic [AMOUNT_W-1:0]  amount,
    input  logic                 another_valid,
    input  logic                 another_service,
    output logic [BALANCE_W-1:0] balance,
    output logic [1:0]           lang_sel,
    output logic [3:0]           state_o,
    output logic [2:0]           status,
    output logic                 status_valid,
    output logic                 session_active
);

    localparam int IDX_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;
    localparam int TRY_W = $clog2(MAX_PIN_TRIES + 1);

    logic [3:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [1:0]           lang_q, lang_d;
    logic [TRY_W-1:0]     tries_q, tries_d;
    logic [BALANCE_W-1:0] bal_q [NUM_ACCOUNTS];
    logic [BALANCE_W-1:0] bal_d [NUM_ACCOUNTS];
    logic [NUM_ACCOUNTS-1:0] lock_q, lock_d;
    logic [2:0]           status_q, status_d;
    logic                 status_valid_q, status_valid_d;
    logic [BALANCE_W-1:0] balance_q, balance_d;
    logic                 active_q, active_d;

    logic                 qual;
    logic                 tmr_clear, tmr_tick, tmr_expired;
    logic [IDX_W-1:0]     card_idx;
    logic [BALANCE_W-1:0] cur_bal, amt_ext;
    logic [BALANCE_W:0]   sum;

    assign card_idx = cardno[IDX_W-1:0];
    assign cur_bal  = bal_q[idx_q];
    assign amt_ext  = BALANCE_W'(amount);
    assign sum      = {1'b0, cur_bal} + {1'b0, amt_ext};

    // Any consumed input restarts the idle window, including a wrong PIN attempt.
    assign tmr_tick  = is_timed_state(state_q);
    assign tmr_clear = qual || (state_d != state_q) || !tmr_tick;

    atm_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear),
        .tick   (tmr_tick),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        lang_d         = lang_q;
        tries_d        = tries_q;
        bal_d          = bal_q;
        lock_d         = lock_q;
        status_d       = status_q;
        status_valid_d = 1'b0;
        qual           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cardno != '0) begin
                    if (lock_q[card_idx]) begin
                        status_d       = ST_LOCKED;
                        status_valid_d = 1'b1;
                    end else begin
                        state_d = S_LANG;
                        idx_d   = card_idx;
                    end
                end
            end
            S_LANG: begin
                if ((language == LANG_EN) || (language == LANG_DE)) begin
                    qual    = 1'b1;
                    state_d = S_PIN;
                    lang_d  = language;
                end
            end
            S_PIN: begin
                if (pin_valid) begin
                    qual = 1'b1;
                    if (pin == correct_pin) begin
                        state_d = S_SERVICE;
                        tries_d = '0;
                    end else if (tries_q == TRY_W'(MAX_PIN_TRIES - 1)) begin
                        lock_d[idx_q]  = 1'b1;
                        status_d       = ST_LOCKED;
                        status_valid_d = 1'b1;
                        state_d        = S_IDLE;
                    end else begin
                        tries_d        = tries_q + 1'b1;
                        status_d       = ST_BADPIN;
                        status_valid_d = 1'b1;
                    end
                end
            end
            S_SERVICE: begin
                qual = 1'b1;
                case (service)
                    SVC_DEPOSIT:  state_d = S_DEPOSIT;
                    SVC_WITHDRAW: state_d = S_WITHDRAW;
                    SVC_BALANCE:  state_d = S_BALANCE;
                    default:      qual    = 1'b0;
                endcase
            end
            S_DEPOSIT: begin
                if (amount != '0) begin
                    qual           = 1'b1;
                    state_d        = S_ANOTHER;
                    status_valid_d = 1'b1;
                    if (sum[BALANCE_W]) begin
                        status_d = ST_OVERFLOW;
                    end else begin
                        bal_d[idx_q] = sum[BALANCE_W-1:0];
                        status_d     = ST_OK;
                    end
                end
            end
            S_WITHDRAW: begin
                if (amount != '0) begin
                    qual           = 1'b1;
                    state_d        = S_ANOTHER;
                    status_valid_d = 1'b1;
                    if (amt_ext > cur_bal) begin
                        status_d = ST_NOFUNDS;
                    end else begin
                        bal_d[idx_q] = cur_bal - amt_ext;
                        status_d     = ST_OK;
                    end
                end
            end
            S_BALANCE: begin
                qual           = 1'b1;
                state_d        = S_ANOTHER;
                status_d       = ST_OK;
                status_valid_d = 1'b1;
            end
            S_ANOTHER: begin
                if (another_valid) begin
                    qual = 1'b1;
                    if (another_service) begin
                        state_d = S_SERVICE;
                    end else begin
                        state_d        = S_IDLE;
                        status_d       = ST_BYE;
                        status_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A qualifying input on the final tolerated cycle takes priority.
        if (tmr_tick && !qual && tmr_expired) begin
            state_d        = S_IDLE;
            status_d       = ST_TIMEOUT;
            status_valid_d = 1'b1;
        end

        if (state_d == S_IDLE) begin
            lang_d  = '0;
            tries_d = '0;
        end

        balance_d = (state_d == S_IDLE) ? '0 : bal_d[idx_d];
        active_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            lang_q         <= '0;
            tries_q        <= '0;
            lock_q         <= '0;
            status_q       <= ST_NONE;
            status_valid_q <= 1'b0;
            balance_q      <= '0;
            active_q       <= 1'b0;
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                bal_q[i] <= BALANCE_W'(INIT_BALANCE);
            end
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            lang_q         <= lang_d;
            tries_q        <= tries_d;
            lock_q         <= lock_d;
            status_q       <= status_d;
            status_valid_q <= status_valid_d;
            balance_q      <= balance_d;
            active_q       <= active_d;
            bal_q          <= bal_d;
        end
    end

    assign balance        = balance_q;
    assign lang_sel       = lang_q;
    assign state_o        = state_q;
    assign status         = status_q;
    assign status_valid   = status_valid_q;
    assign session_active = active_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Scoreboard bench for atm_session_ctrl: stimulus queues expected status events,
// a negedge monitor pops and compares them whenever status_valid pulses.
module tb_atm_session_ctrl;
    import atm_pkg::*;

    localparam int BW = 5;
    localparam logic [3:0] PIN_OK  = 4'hA;
    localparam logic [3:0] PIN_BAD = 4'h3;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    cardno;
    logic [1:0]    language;
    logic [3:0]    pin;
    logic          pin_valid;
    logic [3:0]    correct_pin;
    logic [2:0]    service;
    logic [4:0]    amount;
    logic          another_valid;
    logic          another_service;
    logic [BW-1:0] balance;
    logic [1:0]    lang_sel;
    logic [3:0]    state_o;
    logic [2:0]    status;
    logic          status_valid;
    logic          session_active;

    typedef struct packed {
        logic [2:0]    st;
        logic [3:0]    state;
        logic [BW-1:0] bal;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    atm_session_ctrl #(
        .BALANCE_W(BW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cardno         (cardno),
        .language       (language),
        .pin            (pin),
        .pin_valid      (pin_valid),
        .correct_pin    (correct_pin),
        .service        (service),
        .amount         (amount),
        .another_valid  (another_valid),
        .another_service(another_service),
        .balance        (balance),
        .lang_sel       (lang_sel),
        .state_o        (state_o),
        .status         (status),
        .status_valid   (status_valid),
        .session_active (session_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [2:0] st, input logic [3:0] s, input logic [BW-1:0] b);
        exp_t e;
        e.st    = st;
        e.state = s;
        e.bal   = b;
        exp_q.push_back(e);
    endtask

    // Monitor: every status pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && status_valid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_status: got status %0d state %0d balance %0d, none expected",
                         status, state_o, balance);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event_status",  32'(status),  32'(e.st));
                check("event_state",   32'(state_o), 32'(e.state));
                check("event_balance", 32'(balance), 32'(e.bal));
            end
        end
    end

    task automatic start_session(input logic [7:0] card, input logic [1:0] lang);
        cardno = card;
        step();
        cardno = '0;
        check("enter_lang", 32'(state_o), 32'(S_LANG));
        language = lang;
        step();
        language = '0;
        check("lang_sel", 32'(lang_sel), 32'(lang));
        pin = PIN_OK;
        pin_valid = 1'b1;
        step();
        pin_valid = 1'b0;
        check("enter_service", 32'(state_o), 32'(S_SERVICE));
    endtask

    task automatic txn(input logic [2:0] svc, input logic [4:0] amt,
                       input logic [2:0] st, input logic [BW-1:0] b);
        service = svc;
        step();
        service = '0;
        amount = amt;
        expect_ev(st, S_ANOTHER, b);
        step();
        amount = '0;
    endtask

    task automatic next_service();
        another_valid = 1'b1;
        another_service = 1'b1;
        step();
        another_valid = 1'b0;
        another_service = 1'b0;
    endtask

    task automatic end_session();
        another_valid = 1'b1;
        another_service = 1'b0;
        expect_ev(ST_BYE, S_IDLE, '0);
        step();
        another_valid = 1'b0;
        check("bye_inactive", 32'(session_active), 32'd0);
    endtask

    task automatic lang_timeout(input logic [7:0] card, input logic [BW-1:0] b);
        cardno = card;
        step();
        cardno = '0;
        check("lang_entry_state", 32'(state_o), 32'(S_LANG));
        check("lang_entry_balance", 32'(balance), 32'(b));
        for (int i = 0; i < 4; i++) step();
        expect_ev(ST_TIMEOUT, S_IDLE, '0);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cardno = '0; language = '0; pin = '0; pin_valid = 1'b0; correct_pin = PIN_OK;
        service = '0; amount = '0; another_valid = 1'b0; another_service = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        check("rst_state",   32'(state_o),        32'(S_IDLE));
        check("rst_balance", 32'(balance),        32'd0);
        check("rst_status",  32'(status),         32'(ST_NONE));
        check("rst_valid",   32'(status_valid),   32'd0);
        check("rst_lang",    32'(lang_sel),       32'd0);
        check("rst_active",  32'(session_active), 32'd0);

        // Card 5 (account 1): deposit 10, withdraw 4.
        start_session(8'h05, LANG_EN);
        txn(SVC_DEPOSIT, 5'd10, ST_OK, 5'd10);
        next_service();
        txn(SVC_WITHDRAW, 5'd4, ST_OK, 5'd6);
        end_session();
        check("bye_state", 32'(state_o), 32'(S_IDLE));
        check("bye_lang_cleared", 32'(lang_sel), 32'd0);

        // Insufficient funds, then exact-balance withdraw.
        start_session(8'h05, LANG_EN);
        txn(SVC_WITHDRAW, 5'd7, ST_NOFUNDS, 5'd6);
        next_service();
        txn(SVC_WITHDRAW, 5'd6, ST_OK, 5'd0);
        end_session();

        // Independent accounts 1 and 2.
        start_session(8'h01, LANG_EN);
        txn(SVC_DEPOSIT, 5'd3, ST_OK, 5'd3);
        end_session();
        start_session(8'h02, LANG_DE);
        txn(SVC_DEPOSIT, 5'd9, ST_OK, 5'd9);
        end_session();
        start_session(8'h01, LANG_EN);
        service = SVC_BALANCE;
        step();
        service = '0;
        check("balance_state", 32'(state_o), 32'(S_BALANCE));
        expect_ev(ST_OK, S_ANOTHER, 5'd3);
        step();
        end_session();

        // Card 6 shares account 2 (balance 9): three wrong PINs lock it.
        cardno = 8'h06; step(); cardno = '0;
        language = LANG_EN; step(); language = '0;
        pin = PIN_BAD; pin_valid = 1'b1;
        expect_ev(ST_BADPIN, S_PIN, 5'd9);
        step();
        pin_valid = 1'b0;
        step();
        check("no_attempt_state", 32'(state_o), 32'(S_PIN));
        pin_valid = 1'b1;
        expect_ev(ST_BADPIN, S_PIN, 5'd9);
        step();
        expect_ev(ST_LOCKED, S_IDLE, '0);
        step();
        pin_valid = 1'b0;
        cardno = 8'h06;
        expect_ev(ST_LOCKED, S_IDLE, '0);
        step();
        cardno = '0;
        step();
        check("locked_stays_idle", 32'(state_o), 32'(S_IDLE));
        check("status_held", 32'(status), 32'(ST_LOCKED));
        check("status_pulse_ends", 32'(status_valid), 32'd0);

        // Account 3 in 5-bit balance: overflow boundary.
        start_session(8'h03, LANG_DE);
        txn(SVC_DEPOSIT, 5'd30, ST_OK, 5'd30);
        next_service();
        txn(SVC_DEPOSIT, 5'd5, ST_OVERFLOW, 5'd30);
        next_service();
        txn(SVC_DEPOSIT, 5'd1, ST_OK, 5'd31);
        end_session();

        // SERVICE timeout after five idle cycles.
        start_session(8'h03, LANG_EN);
        for (int i = 0; i < 4; i++) step();
        check("svc_wait_state", 32'(state_o), 32'(S_SERVICE));
        expect_ev(ST_TIMEOUT, S_IDLE, '0);
        step();
        check("timeout_idle", 32'(state_o), 32'(S_IDLE));

        // Valid service on the final cycle wins over timeout.
        start_session(8'h03, LANG_EN);
        for (int i = 0; i < 4; i++) step();
        service = SVC_BALANCE;
        step();
        service = '0;
        check("last_cycle_proceeds", 32'(state_o), 32'(S_BALANCE));
        expect_ev(ST_OK, S_ANOTHER, 5'd31);
        step();
        end_session();

        // Reset in the middle of a deposit.
        start_session(8'h01, LANG_EN);
        service = SVC_DEPOSIT; step(); service = '0;
        check("dep_state", 32'(state_o), 32'(S_DEPOSIT));
        amount = 5'd5;
        rst = 1'b1;
        step();
        rst = 1'b0;
        amount = '0;
        check("midrst_state",   32'(state_o),        32'(S_IDLE));
        check("midrst_balance", 32'(balance),        32'd0);
        check("midrst_status",  32'(status),         32'(ST_NONE));
        check("midrst_active",  32'(session_active), 32'd0);
        lang_timeout(8'h01, 5'd0);
        lang_timeout(8'h02, 5'd0);
        lang_timeout(8'h03, 5'd0);

        step(); step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
